// File: rtl/rst_seq.sv
// Reset sequencer: filters PLL lock, holds all domains, then releases them in ascending order.
// Optional watchdog re-entry is compiled in with `define RST_SEQ_WDT_EN.
module rst_seq #(
    parameter int          N_DOM       = 3,
    parameter int          LOCK_FILT   = 4,
    parameter int          HOLD_CYCLES = 255,
    parameter int          STAGGER     = 16,
    parameter int          CNT_W       = 16,
    parameter logic [23:0] WDT_CYCLES  = 24'hFFFFFF
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_pll_lock,
    input  logic             i_sw_rst_req,
    input  logic             i_wdt_en,
    input  logic             i_wdt_kick,
    output logic [N_DOM-1:0] o_rst_out,
    output logic             o_ready,
    output logic [1:0]       o_last_cause
);

    localparam int LF_W  = (LOCK_FILT > 1) ? $clog2(LOCK_FILT) : 1;
    localparam int IDX_W = (N_DOM > 1) ? $clog2(N_DOM) : 1;

    localparam logic [LF_W-1:0]  LF_MAX   = LF_W'(LOCK_FILT - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAG_MAX = CNT_W'(STAGGER - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DOM - 1);

    localparam logic [1:0] CAUSE_EXT  = 2'd0;
    localparam logic [1:0] CAUSE_LOCK = 2'd1;
    localparam logic [1:0] CAUSE_SW   = 2'd2;
    localparam logic [1:0] CAUSE_WDT  = 2'd3;

    typedef enum logic [1:0] {
        S_ASSERT  = 2'd0,
        S_HOLD    = 2'd1,
        S_RELEASE = 2'd2,
        S_RUN     = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [N_DOM-1:0]  r_rst;
    logic [N_DOM-1:0]  w_rst_nxt;
    logic              r_ready;
    logic              w_ready_nxt;
    logic [1:0]        r_cause;
    logic [1:0]        w_cause_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx_nxt;

    logic              r_lock_ok;
    logic [LF_W-1:0]   r_lock_cnt;
    logic              w_lock_fall;
    logic              w_wdt_exp;
    logic              w_sw_evt;
    logic              w_event;

    // Lock filter: counts consecutive samples that disagree with the filtered state.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_lock_ok  <= 1'b0;
            r_lock_cnt <= '0;
        end else if (i_pll_lock == r_lock_ok) begin
            r_lock_cnt <= '0;
        end else if (r_lock_cnt == LF_MAX) begin
            r_lock_ok  <= i_pll_lock;
            r_lock_cnt <= '0;
        end else begin
            r_lock_cnt <= r_lock_cnt + LF_W'(1);
        end
    end

    // Loss is acted on at the same edge the filter reaches its threshold.
    assign w_lock_fall = r_lock_ok && !i_pll_lock && (r_lock_cnt == LF_MAX);

`ifdef RST_SEQ_WDT_EN
    logic [23:0] r_wdt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wdt <= '0;
        end else if ((r_state == S_RUN) && i_wdt_en && !i_wdt_kick) begin
            r_wdt <= r_wdt + 24'd1;
        end else begin
            r_wdt <= '0;
        end
    end

    // A kick on the terminal edge suppresses expiry.
    assign w_wdt_exp = (r_state == S_RUN) && i_wdt_en && !i_wdt_kick
                       && (r_wdt == WDT_CYCLES - 24'd1);
`else
    wire w_unused = &{1'b0, i_wdt_en, i_wdt_kick, WDT_CYCLES};
    assign w_wdt_exp = 1'b0;
`endif

    assign w_sw_evt = (r_state == S_RUN) && i_sw_rst_req;
    assign w_event  = (r_state != S_ASSERT) && (w_lock_fall || w_wdt_exp || w_sw_evt);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_ASSERT;
            r_rst   <= '1;
            r_ready <= 1'b0;
            r_cause <= CAUSE_EXT;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rst   <= w_rst_nxt;
            r_ready <= w_ready_nxt;
            r_cause <= w_cause_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_ASSERT: begin
                if (r_lock_ok) w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (w_event)
                    w_state_nxt = S_ASSERT;
                else if (r_cnt == HOLD_MAX)
                    w_state_nxt = (N_DOM == 1) ? S_RUN : S_RELEASE;
            end
            S_RELEASE: begin
                if (w_event)
                    w_state_nxt = S_ASSERT;
                else if ((r_cnt == STAG_MAX) && (r_idx == IDX_LAST))
                    w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_event) w_state_nxt = S_ASSERT;
            end
            default: w_state_nxt = S_ASSERT;
        endcase
    end

    always_comb begin
        w_rst_nxt   = r_rst;
        w_ready_nxt = r_ready;
        w_cause_nxt = r_cause;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        case (r_state)
            S_ASSERT: begin
                w_rst_nxt   = '1;
                w_ready_nxt = 1'b0;
                w_cnt_nxt   = '0;
            end
            S_HOLD: begin
                if (r_cnt == HOLD_MAX) begin
                    w_rst_nxt[0] = 1'b0;
                    w_idx_nxt    = IDX_W'(1);
                    w_cnt_nxt    = '0;
                    if (N_DOM == 1) w_ready_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_RELEASE: begin
                if (r_cnt == STAG_MAX) begin
                    w_rst_nxt[r_idx] = 1'b0;
                    w_cnt_nxt        = '0;
                    if (r_idx == IDX_LAST)
                        w_ready_nxt = 1'b1;
                    else
                        w_idx_nxt = r_idx + IDX_W'(1);
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: ;
        endcase
        // Any event overrides sequencing and reasserts every domain, including released ones.
        if (w_event) begin
            w_rst_nxt   = '1;
            w_ready_nxt = 1'b0;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
            if (w_lock_fall)
                w_cause_nxt = CAUSE_LOCK;
            else if (w_wdt_exp)
                w_cause_nxt = CAUSE_WDT;
            else
                w_cause_nxt = CAUSE_SW;
        end
    end

    assign o_rst_out    = r_rst;
    assign o_ready      = r_ready;
    assign o_last_cause = r_cause;

endmodule

// File: doc/rst_seq.md
Name: rst_seq

Overview:
- Parametrised reset sequencer; successor to the single-output post-PLL reset counter in the iCE40 UP5K top level.
- Qualifies PLL lock with a digital filter, holds all resets for a programmable interval, then releases N reset domains in a staggered order (e.g. bus fabric, then core, then peripherals).
- Re-enters reset on external reset, filtered lock loss, software request, or optional watchdog expiry, and records the cause.
- Sits between SB_PLL40_PAD and the system core, clocked by the PLL output.

Parameters:
- N_DOM, 3, number of reset domains (>=1)
- LOCK_FILT, 4, consecutive equal samples needed to change the filtered lock state (>=1)
- HOLD_CYCLES, 255, cycles all resets are held after the filtered lock rises (>=1)
- STAGGER, 16, cycles between successive domain releases (>=1)
- CNT_W, 16, width of the hold/stagger counter; must hold max(HOLD_CYCLES, STAGGER)
- WDT_CYCLES, 24'hFFFFFF, watchdog timeout in cycles (used only with RST_SEQ_WDT_EN)

Ports:
- clk, input, 1, PLL output clock; all logic rising-edge.
- reset, input, 1, synchronous, active-high; forces the ASSERT state.
- pll_lock, input, 1, raw PLL LOCK; treated as synchronous to clk.
- sw_rst_req, input, 1, one-cycle software reset request pulse.
- wdt_en, input, 1, watchdog enable.
- wdt_kick, input, 1, watchdog restart pulse.
- rst_out, output, N_DOM, active-high domain resets; bit 0 is released first.
- ready, output, 1, high when all domains are released.
- last_cause, output, 2, cause of the last reset: 0 = ext, 1 = lock, 2 = sw, 3 = wdt.

Behaviour:
- Reset (reset=1 at an edge):
  - rst_out = all 1s, ready = 0, last_cause = 0.
  - State = ASSERT; counters and lock filter are cleared, with lock_ok = 0.
- Lock filter:
  - lock_ok rises after LOCK_FILT consecutive high samples of pll_lock.
  - lock_ok falls after LOCK_FILT consecutive low samples.
  - A sample opposite to the current state that breaks a run restarts the run count.
- ASSERT:
  - rst_out all 1s, ready = 0.
  - Moves to HOLD on the edge where lock_ok = 1; the counter is cleared.
- HOLD:
  - Counts HOLD_CYCLES cycles.
  - On the final count, clears rst_out[0], sets domain index = 1, clears the counter, and goes to RELEASE.
  - If N_DOM = 1, goes directly to RUN with ready = 1 on the same edge.
- RELEASE:
  - Every STAGGER cycles, clears rst_out[idx] and increments idx.
  - The edge that clears rst_out[N_DOM-1] also sets ready = 1 and moves to RUN.
  - Release order is strictly ascending; a released bit stays 0 until the next reset event.
- RUN: ready = 1, all rst_out = 0.
- Reset events, checked in HOLD/RELEASE/RUN, in priority order (only the highest sets last_cause):
  - reset → ext
  - lock_ok falling → lock
  - watchdog expiry → wdt
  - sw_rst_req → sw
- On a reset event, on the next edge: rst_out all 1s, ready = 0, state = ASSERT, last_cause updated.
- sw_rst_req is honoured only in RUN; it is ignored in ASSERT/HOLD/RELEASE.
- After lock loss, the sequence restarts once lock_ok rises again. A mid-sequence loss during HOLD/RELEASE reasserts all domains already released.
- last_cause holds its value until the next event; it is not cleared by the re-sequence.
- Nominal timing (defaults, pll_lock high from edge 1 after reset drops):
  - lock_ok after edge 4
  - rst_out[0] low after edge 260
  - rst_out[1] low after edge 276
  - rst_out[2] low and ready high after edge 292
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- RST_SEQ_WDT_EN defined:
  - 24-bit watchdog counter runs only in RUN with wdt_en = 1.
  - Cleared by wdt_kick, by wdt_en = 0, and outside RUN.
  - Reaching WDT_CYCLES is a wdt reset event (cause 3).
  - wdt_kick on the same edge as the terminal count wins; no reset occurs.
- RST_SEQ_WDT_EN undefined:
  - No counter logic; wdt_en/wdt_kick remain ports but are ignored.
  - last_cause never equals 3.

Test Plan:
- Power-up: reset high 5 cycles, then pll_lock = 1 → rst_out=111 until edge 260; then 110 at 260, 100 at 276, 000 with ready = 1 at 292; last_cause = 0.
- Lock glitch: in RUN, pll_lock low 3 cycles → no change. pll_lock low 4 cycles → rst_out = 111, ready = 0, last_cause = 1; re-sequence completes 292 edges after lock returns.
- Mid-sequence loss: drop lock for 10 cycles during RELEASE with rst_out = 110 → rst_out = 111, cause = 1. With N_DOM = 1, HOLD_CYCLES = 1, STAGGER = 1: ready rises 2 edges after lock_ok.
- Software reset: sw_rst_req pulse in RUN → rst_out = 111 next edge, last_cause = 2. A pulse during HOLD → ignored.
- Priority: reset, lock-loss threshold and sw_rst_req on the same edge → last_cause = 0; lock-loss and sw together → 1.
- Watchdog (RST_SEQ_WDT_EN, WDT_CYCLES = 100):
  - wdt_en = 1, no kicks → reset at cycle 100, cause = 3.
  - Kick every 50 cycles → no reset.
  - Kick on the terminal edge → no reset.
  - Macro undefined → cause never reaches 3.
